// File: rtl/completion_reorder_pkg.sv
// -----------------------------------------------------------------------------
// completion_reorder_pkg
// Shared definitions for the completion reorder buffer of the TX controller:
//   DATA_W  - default width of read-return data
//   DEPTH   - default number of outstanding request slots
//   TAG_W   - tag / pointer width (log2 of DEPTH)
//   slot_t  - per-slot control bits (the slot data lives in the data RAM)
// -----------------------------------------------------------------------------
package completion_reorder_pkg;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int TAG_W  = $clog2(DEPTH);

    // pending: allocated and not yet popped
    // done:    completion received, waiting to be returned in order
    // is_write: request type captured at allocation
    typedef struct packed {
        logic pending;
        logic done;
        logic is_write;
    } slot_t;

endpackage : completion_reorder_pkg

// File: rtl/completion_reorder_cpl_data_ram.sv
// -----------------------------------------------------------------------------
// completion_reorder_cpl_data_ram
// DEPTH x DATA_W storage for read-return data. One synchronous write port
// (written by the completion side) and one asynchronous read port (addressed
// by the head pointer). Contents are deliberately not reset.
// Ports:
//   i_clk   - clock
//   i_we    - write enable
//   i_waddr - write address (completion tag)
//   i_wdata - write data
//   i_raddr - asynchronous read address (head pointer)
//   o_rdata - read data at i_raddr
// -----------------------------------------------------------------------------
module completion_reorder_cpl_data_ram
    import completion_reorder_pkg::*;
#(
    parameter int DATA_W   = completion_reorder_pkg::DATA_W,
    parameter int DEPTH    = completion_reorder_pkg::DEPTH,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Synchronous write port
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : completion_reorder_cpl_data_ram

// File: rtl/completion_reorder.sv
// -----------------------------------------------------------------------------
// completion_reorder
// Reorder buffer for memory completions. The issue side allocates a slot
// (tag) per request in order; the memory side completes tags in any order;
// the downstream side receives completions strictly in allocation order.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   alloc_valid/ready - slot allocation handshake, alloc_is_write = type
//   alloc_tag         - tag granted to the current allocation (tail pointer)
//   cpl_valid/tag/data- completion report from the memory side
//   out_valid/ready   - in-order completion handshake towards the returner
//   out_is_write      - type of the presented completion
//   out_data          - read data of the presented completion (0 for writes)
//   occupancy         - allocated, not yet popped slots
//   err_bad_cpl       - sticky: completion for a slot not awaiting one
// -----------------------------------------------------------------------------
module completion_reorder
    import completion_reorder_pkg::*;
#(
    parameter int DATA_W  = completion_reorder_pkg::DATA_W,
    parameter int DEPTH   = completion_reorder_pkg::DEPTH,
    localparam int TAG_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    input  logic              alloc_is_write,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cpl_valid,
    input  logic [TAG_W-1:0]  cpl_tag,
    input  logic [DATA_W-1:0] cpl_data,
    output logic              out_valid,
    output logic              out_is_write,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [TAG_W:0]    occupancy,
    output logic              err_bad_cpl
);

    localparam logic [TAG_W:0]   CNT_FULL = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);
    localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);

    slot_t             r_slots [DEPTH];
    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [TAG_W:0]    r_occupancy;
    logic              r_err_bad_cpl;

    slot_t             w_head_slot;
    slot_t             w_cpl_slot;
    logic              w_alloc;
    logic              w_pop;
    logic              w_head_ready;
    logic              w_cpl_ok;
    logic              w_cpl_bad;
    logic              w_ram_we;
    logic [DATA_W-1:0] w_ram_rdata;

    // Handshake and completion qualification, all from registered state
    always_comb begin
        w_head_slot  = r_slots[r_head];
        w_cpl_slot   = r_slots[cpl_tag];
        // Full check uses registered occupancy only: a same-cycle pop never
        // frees a slot for allocation.
        alloc_ready  = (r_occupancy < CNT_FULL);
        w_alloc      = alloc_valid && alloc_ready;
        w_head_ready = w_head_slot.pending && w_head_slot.done;
        w_pop        = w_head_ready && out_ready;
        // A slot being allocated this cycle still reads pending=0, so a
        // completion aimed at it is rejected as bad.
        w_cpl_ok     = cpl_valid && w_cpl_slot.pending && !w_cpl_slot.done;
        w_cpl_bad    = cpl_valid && !w_cpl_ok;
        w_ram_we     = w_cpl_ok && !w_cpl_slot.is_write;
    end

    // Slot control bits: pop clears head, completion marks done, allocation
    // opens tail. The three never address the same slot in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slots[i] <= '0;
            end
        end else begin
            if (w_pop) begin
                r_slots[r_head].pending <= 1'b0;
                r_slots[r_head].done    <= 1'b0;
            end
            if (w_cpl_ok) begin
                r_slots[cpl_tag].done <= 1'b1;
            end
            if (w_alloc) begin
                r_slots[r_tail].pending  <= 1'b1;
                r_slots[r_tail].done     <= 1'b0;
                r_slots[r_tail].is_write <= alloc_is_write;
            end
        end
    end

    // Pointers, occupancy counter and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_occupancy   <= '0;
            r_err_bad_cpl <= 1'b0;
        end else begin
            if (w_alloc) begin
                r_tail <= r_tail + TAG_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + TAG_ONE;
            end
            case ({w_alloc, w_pop})
                2'b10:   r_occupancy <= r_occupancy + CNT_ONE;
                2'b01:   r_occupancy <= r_occupancy - CNT_ONE;
                default: r_occupancy <= r_occupancy;
            endcase
            r_err_bad_cpl <= r_err_bad_cpl | w_cpl_bad;
        end
    end

    completion_reorder_cpl_data_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_cpl_data_ram (
        .i_clk   (clk),
        .i_we    (w_ram_we),
        .i_waddr (cpl_tag),
        .i_wdata (cpl_data),
        .i_raddr (r_head),
        .o_rdata (w_ram_rdata)
    );

    // Output presentation: type and data are masked when nothing is valid,
    // and data is forced to zero for write completions.
    always_comb begin
        out_valid    = w_head_ready;
        out_is_write = 1'b0;
        out_data     = '0;
        if (w_head_ready) begin
            out_is_write = w_head_slot.is_write;
            if (!w_head_slot.is_write) begin
                out_data = w_ram_rdata;
            end else begin
                out_data = '0;
            end
        end else begin
            out_is_write = 1'b0;
            out_data     = '0;
        end
    end

    assign alloc_tag   = r_tail;
    assign occupancy   = r_occupancy;
    assign err_bad_cpl = r_err_bad_cpl;

endmodule : completion_reorder
